multi_lookup_arbiter: RTL

MULTI_LOOKUP_ARBITER -- requirements
Module: multi_lookup_arbiter

---
 rtl/multi_lookup_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multi_lookup_arbiter.sv
// multi_lookup_arbiter: round-robin key issue from per-channel FIFOs, in-order result return with sqn pairing
module multi_lookup_arbiter #(
    parameter int N_CH           = 4,
    parameter int KEY_W          = 96,
    parameter int SQN_W          = 32,
    parameter int ID_W           = 23,
    parameter int TIME_W         = 64,
    parameter int KEY_DEPTH_BITS = 4,
    parameter int SQN_DEPTH_BITS = 8,
    parameter int ORD_DEPTH_BITS = 9,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           in_valid_key,
    input  logic [N_CH*KEY_W-1:0]     in_key,
    input  logic [N_CH-1:0]           in_valid_sqn,
    input  logic [N_CH*SQN_W-1:0]     in_sqn,
    input  logic                      tbl_ready,
    output logic                      out_key_valid,
    output logic [KEY_W-1:0]          out_key,
    input  logic                      in_valid_id,
    input  logic [ID_W-1:0]           in_id,
    output logic [N_CH-1:0]           out_valid,
    output logic [TIME_W-1:0]         out_time,
    output logic [SQN_W-1:0]          out_sqn,
    output logic [ID_W-1:0]           out_id,
    output logic [CH_W-1:0]           out_ch,
    output logic [ORD_DEPTH_BITS:0]   outstanding,
    output logic [15:0]               drop_cnt,
    output logic                      err_orphan,
    output logic                      err_sqn_uf
);
    localparam int KD = 1 << KEY_DEPTH_BITS;
    localparam int SD = 1 << SQN_DEPTH_BITS;
    localparam int OD = 1 << ORD_DEPTH_BITS;

    logic [KEY_W-1:0]          key_mem [N_CH][KD];
    logic [KEY_DEPTH_BITS-1:0] key_wp  [N_CH];
    logic [KEY_DEPTH_BITS-1:0] key_rp  [N_CH];
    logic [KEY_DEPTH_BITS:0]   key_cnt [N_CH];
    logic [SQN_W-1:0]          sqn_mem [N_CH][SD];
    logic [SQN_DEPTH_BITS-1:0] sqn_wp  [N_CH];
    logic [SQN_DEPTH_BITS-1:0] sqn_rp  [N_CH];
    logic [SQN_DEPTH_BITS:0]   sqn_cnt [N_CH];
    logic [CH_W-1:0]           ord_mem [OD];
    logic [ORD_DEPTH_BITS-1:0] ord_wp, ord_rp;
    logic [ORD_DEPTH_BITS:0]   ord_cnt;
    logic [CH_W-1:0]           rr;
    logic [TIME_W-1:0]         ts;

    logic [N_CH-1:0] key_ne, key_wr, key_drop, key_pop;
    logic [N_CH-1:0] sqn_ne, sqn_wr, sqn_drop, sqn_pop;
    logic            gnt_ok, found, rsp;
    logic [CH_W-1:0] gnt_ch, rsp_ch;
    logic [4:0]      n_drop;
    logic [16:0]     drop_sum;
    int              idx;

    assign outstanding = ord_cnt;
    assign rsp         = in_valid_id && (ord_cnt != '0);
    assign rsp_ch      = ord_mem[ord_rp];
    assign drop_sum    = {1'b0, drop_cnt} + 17'(n_drop);

    // FIFO status, write/drop qualification and per-cycle drop tally
    always_comb begin
        n_drop = '0;
        for (int c = 0; c < N_CH; c++) begin
            key_ne[c]   = key_cnt[c] != '0;
            key_wr[c]   = in_valid_key[c] && (key_cnt[c] != (KEY_DEPTH_BITS+1)'(KD));
            key_drop[c] = in_valid_key[c] && (key_cnt[c] == (KEY_DEPTH_BITS+1)'(KD));
            key_pop[c]  = gnt_ok && (gnt_ch == CH_W'(c));
            sqn_ne[c]   = sqn_cnt[c] != '0;
            sqn_wr[c]   = in_valid_sqn[c] && (sqn_cnt[c] != (SQN_DEPTH_BITS+1)'(SD));
            sqn_drop[c] = in_valid_sqn[c] && (sqn_cnt[c] == (SQN_DEPTH_BITS+1)'(SD));
            sqn_pop[c]  = rsp && (rsp_ch == CH_W'(c)) && sqn_ne[c];
            n_drop      = n_drop + 5'(key_drop[c]) + 5'(sqn_drop[c]);
        end
    end

    // Round-robin search: scanning from the far end leaves the nearest non-empty channel at or after rr
    always_comb begin
        found  = 1'b0;
        gnt_ch = '0;
        idx    = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(rr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (key_ne[idx]) begin
                gnt_ch = CH_W'(idx);
                found  = 1'b1;
            end
        end
        gnt_ok = found && tbl_ready && (ord_cnt != (ORD_DEPTH_BITS+1)'(OD));
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (key_wr[c]) key_mem[c][key_wp[c]] <= in_key[c*KEY_W +: KEY_W];
            if (sqn_wr[c]) sqn_mem[c][sqn_wp[c]] <= in_sqn[c*SQN_W +: SQN_W];
        end
        if (gnt_ok) ord_mem[ord_wp] <= gnt_ch;
    end

    // FIFO pointers/counts, round-robin pointer, timestamp and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                key_wp[c]  <= '0;
                key_rp[c]  <= '0;
                key_cnt[c] <= '0;
                sqn_wp[c]  <= '0;
                sqn_rp[c]  <= '0;
                sqn_cnt[c] <= '0;
            end
            ord_wp   <= '0;
            ord_rp   <= '0;
            ord_cnt  <= '0;
            rr       <= '0;
            ts       <= '0;
            drop_cnt <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (key_wr[c])  key_wp[c] <= key_wp[c] + KEY_DEPTH_BITS'(1);
                if (key_pop[c]) key_rp[c] <= key_rp[c] + KEY_DEPTH_BITS'(1);
                key_cnt[c] <= key_cnt[c] + (KEY_DEPTH_BITS+1)'(key_wr[c]) - (KEY_DEPTH_BITS+1)'(key_pop[c]);
                if (sqn_wr[c])  sqn_wp[c] <= sqn_wp[c] + SQN_DEPTH_BITS'(1);
                if (sqn_pop[c]) sqn_rp[c] <= sqn_rp[c] + SQN_DEPTH_BITS'(1);
                sqn_cnt[c] <= sqn_cnt[c] + (SQN_DEPTH_BITS+1)'(sqn_wr[c]) - (SQN_DEPTH_BITS+1)'(sqn_pop[c]);
            end
            if (gnt_ok) ord_wp <= ord_wp + ORD_DEPTH_BITS'(1);
            if (rsp)    ord_rp <= ord_rp + ORD_DEPTH_BITS'(1);
            ord_cnt  <= ord_cnt + (ORD_DEPTH_BITS+1)'(gnt_ok) - (ORD_DEPTH_BITS+1)'(rsp);
            if (gnt_ok) rr <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            ts       <= ts + TIME_W'(1);
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Registered key issue and result outputs; result fields are zero whenever out_valid is zero
    always_ff @(posedge clk) begin
        if (reset) begin
            out_key_valid <= 1'b0;
            out_key       <= '0;
            out_valid     <= '0;
            out_time      <= '0;
            out_sqn       <= '0;
            out_id        <= '0;
            out_ch        <= '0;
            err_orphan    <= 1'b0;
            err_sqn_uf    <= 1'b0;
        end else begin
            out_key_valid <= gnt_ok;
            if (gnt_ok) out_key <= key_mem[gnt_ch][key_rp[gnt_ch]];
            out_valid     <= rsp ? (N_CH'(1) << rsp_ch) : '0;
            out_time      <= rsp ? ts : '0;
            out_sqn       <= (rsp && sqn_ne[rsp_ch]) ? sqn_mem[rsp_ch][sqn_rp[rsp_ch]] : '0;
            out_id        <= rsp ? in_id : '0;
            out_ch        <= rsp ? rsp_ch : '0;
            err_orphan    <= in_valid_id && !rsp;
            err_sqn_uf    <= rsp && !sqn_ne[rsp_ch];
        end
    end
endmodule
